// File: rtl/apb_dsz_pkg.sv
// Shared types and helpers for the APB wide-to-narrow downsizer.
package apb_dsz_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2,
        DONE     = 2'd3
    } dsz_state_e;

    // Beat counter width: clog2 of the beat count, never narrower than one bit.
    function automatic int beat_w(input int s_dw, input int m_dw);
        int n;
        n = s_dw / m_dw;
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_dsz_if.sv
// APB bus bundle; the same interface serves the wide slave side and the narrow master side.
interface apb_dsz_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_dsz_beat_sel.sv
// Finds the next beat to issue: reads take every beat, writes skip beats with an all-zero strobe slice.
module apb_dsz_beat_sel
    import apb_dsz_pkg::*;
#(
    parameter int S_DW = 32,
    parameter int M_DW = 16,
    localparam int N   = S_DW / M_DW,
    localparam int BW  = beat_w(S_DW, M_DW),
    localparam int MSW = M_DW / 8
) (
    input  logic [S_DW/8-1:0] strb_i,
    input  logic              write_i,
    input  logic [BW-1:0]     beat_i,
    input  logic              first_i,
    output logic [BW-1:0]     next_o,
    output logic              none_o
);
    logic [N-1:0] qual;

    always_comb begin
        qual = '0;
        for (int b = 0; b < N; b++) begin
            qual[b] = !write_i || (|strb_i[b*MSW +: MSW]);
        end
    end

    // Scan downwards so the lowest qualifying beat at or after the start wins.
    always_comb begin
        int start;
        start  = first_i ? 0 : int'(beat_i) + 1;
        next_o = '0;
        none_o = 1'b1;
        for (int b = N - 1; b >= 0; b--) begin
            if (b >= start && qual[b]) begin
                next_o = BW'(b);
                none_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/apb_downsizer_param.sv
// APB width converter: each wide slave transfer becomes a run of narrow master beats,
// with strobe-based write skipping, error aggregation and optional abort on first error.
module apb_downsizer_param
    import apb_dsz_pkg::*;
#(
    parameter int AW        = 8,
    parameter int S_DW      = 32,
    parameter int M_DW      = 16,
    parameter int ERR_ABORT = 0
) (
    input logic       PCLK,
    input logic       PRESET,
    apb_dsz_if.slave  slv,
    apb_dsz_if.master mst
);
    localparam int BW  = beat_w(S_DW, M_DW);
    localparam int SSW = S_DW / 8;
    localparam int MSW = M_DW / 8;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(SSW - 1);
    localparam logic [AW-1:0] BEAT_STEP  = AW'(MSW);

    dsz_state_e      state_q, state_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [S_DW-1:0] wdata_q, wdata_d;
    logic [SSW-1:0]  strb_q, strb_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            err_q, err_d;
    logic [S_DW-1:0] rdbuf_q, rdbuf_d;
    logic            drop_q, drop_d;

    logic            idle, in_beat, in_done;
    logic [SSW-1:0]  sel_strb;
    logic            sel_wr;
    logic [BW-1:0]   sel_next;
    logic            sel_none;

    assign idle    = (state_q == IDLE);
    assign in_beat = (state_q == M_SETUP) || (state_q == M_ACCESS);
    assign in_done = (state_q == DONE);

    // In IDLE the first beat is chosen from the live request, before it is captured.
    assign sel_strb = idle ? slv.pstrb  : strb_q;
    assign sel_wr   = idle ? slv.pwrite : wr_q;

    apb_dsz_beat_sel #(
        .S_DW (S_DW),
        .M_DW (M_DW)
    ) u_beat_sel (
        .strb_i  (sel_strb),
        .write_i (sel_wr),
        .beat_i  (beat_q),
        .first_i (idle),
        .next_o  (sel_next),
        .none_o  (sel_none)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rdbuf_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rdbuf_q <= rdbuf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        beat_d  = beat_q;
        err_d   = err_q;
        rdbuf_d = rdbuf_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (slv.psel && !slv.penable) begin
                    wr_d    = slv.pwrite;
                    addr_d  = slv.paddr;
                    wdata_d = slv.pwdata;
                    strb_d  = slv.pstrb;
                    err_d   = 1'b0;
                    rdbuf_d = '0;
                    drop_d  = 1'b0;
                    beat_d  = sel_next;
                    state_d = sel_none ? DONE : M_SETUP;
                end
            end
            M_SETUP: begin
                drop_d  = drop_q | ~slv.psel;
                state_d = M_ACCESS;
            end
            M_ACCESS: begin
                // A requester that walks away still lets the in-flight beat finish.
                drop_d = drop_q | ~slv.psel;
                if (mst.pready) begin
                    if (!wr_q) rdbuf_d[beat_q*M_DW +: M_DW] = mst.prdata;
                    err_d = err_q | mst.pslverr;
                    if (drop_q || !slv.psel) begin
                        state_d = IDLE;
                    end else if (sel_none || (ERR_ABORT != 0 && mst.pslverr)) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = sel_next;
                        state_d = M_SETUP;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mst.psel    = in_beat;
    assign mst.penable = (state_q == M_ACCESS);
    assign mst.pwrite  = in_beat & wr_q;
    assign mst.paddr   = in_beat ? (addr_q & ALIGN_MASK) + AW'(beat_q) * BEAT_STEP : '0;
    assign mst.pwdata  = (in_beat && wr_q) ? wdata_q[beat_q*M_DW +: M_DW] : '0;
    assign mst.pstrb   = (in_beat && wr_q) ? strb_q[beat_q*MSW +: MSW] : '0;

    assign slv.pready  = in_done;
    assign slv.pslverr = in_done & err_q;
    assign slv.prdata  = (in_done && !wr_q) ? rdbuf_q : '0;
endmodule

// File: tb/tb_apb_downsizer_param.sv
// Bench for apb_downsizer_param: two instances (run-all and abort-on-error) see the same traffic.
module tb_apb_downsizer_param;
    localparam int AW   = 8;
    localparam int S_DW = 32;
    localparam int M_DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_dsz_if #(.AW(AW), .DW(S_DW)) s_if0 ();
    apb_dsz_if #(.AW(AW), .DW(S_DW)) s_if1 ();
    apb_dsz_if #(.AW(AW), .DW(M_DW)) m_if0 ();
    apb_dsz_if #(.AW(AW), .DW(M_DW)) m_if1 ();

    apb_downsizer_param #(.AW(AW), .S_DW(S_DW), .M_DW(M_DW), .ERR_ABORT(0)) dut0 (
        .PCLK (clk), .PRESET (rst), .slv (s_if0), .mst (m_if0));
    apb_downsizer_param #(.AW(AW), .S_DW(S_DW), .M_DW(M_DW), .ERR_ABORT(1)) dut1 (
        .PCLK (clk), .PRESET (rst), .slv (s_if1), .mst (m_if1));

    logic        s_psel = 1'b0, s_pen = 1'b0, s_wr = 1'b0;
    logic [7:0]  s_addr = '0;
    logic [31:0] s_wd = '0;
    logic [3:0]  s_st = '0;
    logic        m_rdy[2];
    logic        m_err[2];
    logic [15:0] m_rd[2];

    assign s_if0.psel = s_psel;  assign s_if1.psel = s_psel;
    assign s_if0.penable = s_pen; assign s_if1.penable = s_pen;
    assign s_if0.pwrite = s_wr;  assign s_if1.pwrite = s_wr;
    assign s_if0.paddr = s_addr; assign s_if1.paddr = s_addr;
    assign s_if0.pwdata = s_wd;  assign s_if1.pwdata = s_wd;
    assign s_if0.pstrb = s_st;   assign s_if1.pstrb = s_st;
    assign m_if0.pready = m_rdy[0]; assign m_if1.pready = m_rdy[1];
    assign m_if0.pslverr = m_err[0]; assign m_if1.pslverr = m_err[1];
    assign m_if0.prdata = m_rd[0];  assign m_if1.prdata = m_rd[1];

    logic        mpsel[2], mpen[2], mwr[2], spready[2], sperr[2];
    logic [7:0]  maddr[2];
    logic [15:0] mwdata[2];
    logic [1:0]  mstrb[2];
    logic [31:0] sprdata[2];

    assign mpsel[0] = m_if0.psel;     assign mpsel[1] = m_if1.psel;
    assign mpen[0] = m_if0.penable;   assign mpen[1] = m_if1.penable;
    assign mwr[0] = m_if0.pwrite;     assign mwr[1] = m_if1.pwrite;
    assign maddr[0] = m_if0.paddr;    assign maddr[1] = m_if1.paddr;
    assign mwdata[0] = m_if0.pwdata;  assign mwdata[1] = m_if1.pwdata;
    assign mstrb[0] = m_if0.pstrb;    assign mstrb[1] = m_if1.pstrb;
    assign spready[0] = s_if0.pready; assign spready[1] = s_if1.pready;
    assign sperr[0] = s_if0.pslverr;  assign sperr[1] = s_if1.pslverr;
    assign sprdata[0] = s_if0.prdata; assign sprdata[1] = s_if1.prdata;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One wide transfer on both instances; master side answers from a per-beat plan.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [15:0] rd0, input logic [15:0] rd1,
                           input logic er0, input logic er1, input int wt0, input int wt1);
        logic [15:0] rdv[2];
        logic        erv[2];
        int          wtv[2];
        logic [7:0]  base;
        logic [7:0]  e_addr[2][2];
        logic [15:0] e_wd[2][2];
        logic [1:0]  e_st[2][2];
        int          e_n[2], e_cyc[2], got_n[2], wcnt[2], bidx[2];
        logic [31:0] e_rd[2];
        logic        e_err[2], done[2];
        logic [7:0]  off;
        int          cyc;
        rdv[0] = rd0; rdv[1] = rd1;
        erv[0] = er0; erv[1] = er1;
        wtv[0] = wt0; wtv[1] = wt1;
        base = addr & 8'hFC;
        for (int d = 0; d < 2; d++) begin
            logic stop;
            stop = 1'b0;
            e_n[d] = 0; e_cyc[d] = 2; e_rd[d] = '0; e_err[d] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (!stop && (!wr || st[2*b +: 2] != 2'b00)) begin
                    e_addr[d][e_n[d]] = base + 8'(2 * b);
                    e_wd[d][e_n[d]]   = wr ? wd[16*b +: 16] : 16'h0;
                    e_st[d][e_n[d]]   = wr ? st[2*b +: 2] : 2'b00;
                    e_n[d]++;
                    e_err[d] = e_err[d] | erv[b];
                    if (!wr) e_rd[d][16*b +: 16] = rdv[b];
                    e_cyc[d] += 2 + wtv[b];
                    if (d == 1 && erv[b]) stop = 1'b1;
                end
            end
            got_n[d] = 0; wcnt[d] = 0; bidx[d] = 0; done[d] = 1'b0;
            m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_rd[d] = '0;
        end
        s_psel = 1'b1; s_pen = 1'b0; s_wr = wr; s_addr = addr; s_wd = wd; s_st = st;
        cyc = 1;
        while (!(done[0] && done[1]) && cyc < 64) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            s_pen = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (!done[d]) begin
                    m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_rd[d] = '0;
                    if (spready[d]) begin
                        done[d] = 1'b1;
                        chk_eq($sformatf("latency[%0d]", d), 32'(cyc), 32'(e_cyc[d]));
                        chk_eq($sformatf("n_beats[%0d]", d), 32'(got_n[d]), 32'(e_n[d]));
                        chk_eq($sformatf("prdata[%0d]", d), sprdata[d], e_rd[d]);
                        chk_eq($sformatf("pslverr[%0d]", d), 32'(sperr[d]), 32'(e_err[d]));
                    end else if (mpsel[d] && !mpen[d]) begin
                        off = maddr[d] - base;
                        bidx[d] = int'(off[1]);
                        wcnt[d] = wtv[bidx[d]];
                    end else if (mpsel[d] && mpen[d]) begin
                        if (wcnt[d] == 0) begin
                            m_rdy[d] = 1'b1;
                            m_err[d] = erv[bidx[d]];
                            m_rd[d]  = rdv[bidx[d]];
                            if (got_n[d] < e_n[d]) begin
                                chk_eq($sformatf("paddr[%0d]", d), 32'(maddr[d]), 32'(e_addr[d][got_n[d]]));
                                chk_eq($sformatf("pwdata[%0d]", d), 32'(mwdata[d]), 32'(e_wd[d][got_n[d]]));
                                chk_eq($sformatf("pstrb[%0d]", d), 32'(mstrb[d]), 32'(e_st[d][got_n[d]]));
                                chk_eq($sformatf("pwrite[%0d]", d), 32'(mwr[d]), 32'(wr));
                            end else begin
                                chk_eq($sformatf("extra_beat[%0d]", d), 32'(got_n[d] + 1), 32'(e_n[d]));
                            end
                            got_n[d]++;
                        end else begin
                            wcnt[d]--;
                        end
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (!done[d]) chk_eq($sformatf("timeout[%0d]", d), 32'd0, 32'd1);
            m_rdy[d] = 1'b0;
        end
        s_psel = 1'b0; s_pen = 1'b0;
        @(negedge clk);
    endtask

    // Requester abandons the transfer while the first master beat is in setup.
    task automatic drop_txn();
        int beats[2];
        logic saw[2];
        beats[0] = 0; beats[1] = 0; saw[0] = 1'b0; saw[1] = 1'b0;
        s_psel = 1'b1; s_pen = 1'b0; s_wr = 1'b1; s_addr = 8'h10; s_wd = 32'h1234_5678; s_st = 4'hF;
        @(posedge clk);
        @(negedge clk);
        s_psel = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m_rdy[d] = 1'b0;
                if (mpsel[d] && mpen[d]) begin
                    m_rdy[d] = 1'b1;
                    beats[d]++;
                end
                if (spready[d]) saw[d] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("drop_beats[%0d]", d), 32'(beats[d]), 32'd1);
            chk_eq($sformatf("drop_pready[%0d]", d), 32'(saw[d]), 32'd0);
            chk_eq($sformatf("drop_idle_psel[%0d]", d), 32'(mpsel[d]), 32'd0);
            m_rdy[d] = 1'b0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_rd[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("rst_psel[%0d]", d), 32'(mpsel[d]), 32'd0);
            chk_eq($sformatf("rst_penable[%0d]", d), 32'(mpen[d]), 32'd0);
            chk_eq($sformatf("rst_paddr[%0d]", d), 32'(maddr[d]), 32'd0);
            chk_eq($sformatf("rst_pready[%0d]", d), 32'(spready[d]), 32'd0);
            chk_eq($sformatf("rst_prdata[%0d]", d), sprdata[d], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 8'hA0, 32'hDEAD_BEEF, 4'hF, 16'h0, 16'h0, 1'b0, 1'b0, 0, 0);
        run_txn(1'b0, 8'h43, 32'h0, 4'h0, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h50, 32'hCAFE_F00D, 4'hC, 16'h0, 16'h0, 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h50, 32'hCAFE_F00D, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0, 0);
        run_txn(1'b0, 8'h60, 32'h0, 4'h0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 0, 0);
        run_txn(1'b1, 8'h64, 32'h0102_0304, 4'hF, 16'h0, 16'h0, 1'b1, 1'b0, 1, 0);
        run_txn(1'b0, 8'hFE, 32'h0, 4'h0, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 0, 3);

        drop_txn();
        run_txn(1'b0, 8'h12, 32'h0, 4'h0, 16'h7777, 16'h8888, 1'b0, 1'b0, 0, 0);

        // Reset lands while the first master beat is in its access phase.
        s_psel = 1'b1; s_pen = 1'b0; s_wr = 1'b0; s_addr = 8'h20;
        @(posedge clk); @(negedge clk);
        s_pen = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("arst_psel[%0d]", d), 32'(mpsel[d]), 32'd0);
            chk_eq($sformatf("arst_penable[%0d]", d), 32'(mpen[d]), 32'd0);
        end
        s_psel = 1'b0; s_pen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 8'h20, 32'h0, 4'h0, 16'h3333, 16'h4444, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
                    16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
